trap_sequencer: RTL and testbench
=================================

# trap_sequencer

Sequences supervisor trap entry and return around `exception_handler` in the pipelined core. When an exception is flagged, the block captures `sepc` and `scause`, then flushes the pipeline for a fixed number of cycles. It then redirects fetch to the trap vector (`stvec`), tracks handler residency, and on `sret` redirects fetch back to the saved PC. A fault raised while the handler is already running parks the core in a halted state until reset.

## Interface
Parameters:
- `PC_W`, 15, width of PC, `sepc` and `stvec`.
- `CAUSE_W`, 64, width of `scause`.
- `FLUSH_CYCLES`, 3, number of cycles flush and stall are held on trap entry (legal range 1–15).
- `STVEC_RESET`, 15'h0100, `stvec` value after reset.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `exception_in`  in  1  exception flag from `exception_handler`.
- `sepc_in`  in  PC_W  faulting PC from `exception_handler`.
- `scause_in`  in  CAUSE_W  cause code from `exception_handler`.
- `sret_in`  in  1  an SRET instruction is in EXE.
- `stvec_wr_en`  in  1  CSR write strobe for `stvec`.
- `stvec_wr_data`  in  PC_W  new `stvec` value.
- `flush_if_id`, `flush_id_ex`, `flush_ex_mem`  out  1 each  pipeline-register flushes.
- `stall_pc`  out  1  hold the PC register.
- `pc_redirect_valid`  out  1  fetch must load `pc_redirect_addr` this cycle.
- `pc_redirect_addr`  out  PC_W  redirect target.
- `sepc_q`  out  PC_W  saved exception PC.
- `scause_q`  out  CAUSE_W  saved cause.
- `stvec_q`  out  PC_W  current trap vector.
- `in_trap`  out  1  handler is executing.
- `halted`  out  1  double fault; core is frozen.

## Operation
- State machine states: IDLE, FLUSH, REDIRECT, HANDLER, RETURN, HALT.
- IDLE:
  - `exception_in`=1 → latch `sepc_in`→`sepc_q` and `scause_in`→`scause_q`, load the flush counter with FLUSH_CYCLES-1, go to FLUSH.
  - `sret_in` in IDLE is ignored; no redirect is issued.
- FLUSH:
  - All three flushes and `stall_pc` are high.
  - Counter decrements each cycle; at 0, go to REDIRECT.
  - `exception_in` and `sret_in` are ignored (those instructions are being flushed).
- REDIRECT: one cycle.
  - `pc_redirect_valid`=1, `pc_redirect_addr`=`stvec_q`, `flush_if_id`=1.
  - Go to HANDLER.
- HANDLER:
  - `in_trap`=1.
  - `exception_in`=1 → HALT. This takes priority over a simultaneous `sret_in`, and `sepc_q`/`scause_q` are not overwritten.
  - `sret_in`=1 alone → RETURN.
- RETURN: one cycle.
  - `pc_redirect_valid`=1, `pc_redirect_addr`=`sepc_q`, `flush_if_id`=`flush_id_ex`=1, `in_trap`=1.
  - Go to IDLE. `exception_in` in this cycle is ignored.
- HALT:
  - `halted`=1 and `stall_pc`=1, with all three flushes held high.
  - Only `rst_n` exits this state.
- `stvec` handling:
  - `stvec_q` is written whenever `stvec_wr_en`=1, in any state except HALT.
  - Stored value is `{stvec_wr_data[PC_W-1:2], 2'b00}` (word aligned).
- `pc_redirect_addr` is 0 whenever `pc_redirect_valid`=0.

## Timing
- Reset (`rst_n`=0 at a rising edge) applies in every state, including mid-FLUSH and HALT. Values after reset:
  - state = IDLE.
  - `sepc_q`=0, `scause_q`=0, `stvec_q`=STVEC_RESET with bits [1:0] forced to 0.
  - `in_trap`=0, `halted`=0, all flushes = 0, `stall_pc`=0, `pc_redirect_valid`=0, `pc_redirect_addr`=0.
- All outputs are decoded from registered state; there are no combinational paths from inputs to outputs.
- Trap entry timing:
  - `exception_in` sampled at edge N.
  - Flush/stall high in cycles N+1 … N+FLUSH_CYCLES.
  - Redirect in cycle N+FLUSH_CYCLES+1.
  - `in_trap` rises in cycle N+FLUSH_CYCLES+2.
- `sret_in` sampled at edge M in HANDLER → redirect to `sepc_q` in cycle M+1 → IDLE in cycle M+2.
- A `stvec` write at edge K is used by any REDIRECT in cycle K+1 or later. A write sampled on the same edge that enters REDIRECT is therefore visible in REDIRECT.
- Back-to-back traps: an `exception_in` sampled in the first IDLE cycle after RETURN starts a new trap and overwrites `sepc_q` and `scause_q`.

## Test plan
- Basic trap entry:
  - Stimulus: reset, `stvec` at reset value; `exception_in`=1 for one cycle with `sepc_in`=15'h1000, `scause_in`=64'h2.
  - Required: flushes and `stall_pc` high for exactly 3 cycles; then one cycle with `pc_redirect_valid`=1, addr=15'h0100; then `in_trap`=1; `sepc_q`=15'h1000, `scause_q`=2.
- Return:
  - Stimulus: from HANDLER, pulse `sret_in`.
  - Required: next cycle `pc_redirect_valid`=1, addr=15'h1000, `flush_if_id`=`flush_id_ex`=1; following cycle `in_trap`=0.
- Double fault:
  - Stimulus: in HANDLER, assert `exception_in` and `sret_in` together with `sepc_in`=15'h1004.
  - Required: `halted`=1 and never leaves HALT; `sepc_q` stays 15'h1000; a subsequent `rst_n`=0 clears all outputs to their reset values.
- `stvec` write:
  - Stimulus: write `stvec_wr_data`=15'h2003, then trap.
  - Required: `stvec_q`=15'h2000 and redirect addr=15'h2000.
- Ignored events:
  - Stimulus: `sret_in` in IDLE, and `exception_in` during FLUSH.
  - Required: no redirect from the `sret_in`; `sepc_q`/`scause_q` unchanged; FLUSH length unchanged.
- Reset mid-FLUSH:
  - Stimulus: `rst_n`=0 in the second FLUSH cycle.
  - Required: next cycle state is IDLE, all flushes=0, `sepc_q`=0.

Source files
------------

// File: rtl/trap_sequencer.sv
// Supervisor trap entry/return sequencer: flush, vector redirect, handler residency, sret return, double-fault halt.
// Latency: exception sampled at edge N -> flush N+1..N+FLUSH_CYCLES, redirect N+FLUSH_CYCLES+1; sret at M -> redirect M+1.
// Backpressure: none; events outside IDLE/HANDLER are dropped, and HALT freezes everything until reset.
module trap_sequencer #(
    parameter int              PC_W         = 15,
    parameter int              CAUSE_W      = 64,
    parameter int              FLUSH_CYCLES = 3,
    parameter logic [PC_W-1:0] STVEC_RESET  = 'h0100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               exception_in,
    input  logic [PC_W-1:0]    sepc_in,
    input  logic [CAUSE_W-1:0] scause_in,
    input  logic               sret_in,
    input  logic               stvec_wr_en,
    input  logic [PC_W-1:0]    stvec_wr_data,
    output logic               flush_if_id,
    output logic               flush_id_ex,
    output logic               flush_ex_mem,
    output logic               stall_pc,
    output logic               pc_redirect_valid,
    output logic [PC_W-1:0]    pc_redirect_addr,
    output logic [PC_W-1:0]    sepc_q,
    output logic [CAUSE_W-1:0] scause_q,
    output logic [PC_W-1:0]    stvec_q,
    output logic               in_trap,
    output logic               halted
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FLUSH    = 3'd1,
        REDIRECT = 3'd2,
        HANDLER  = 3'd3,
        RETURN   = 3'd4,
        HALT     = 3'd5
    } state_t;

    localparam logic [PC_W-1:0] WORD_MASK  = {{(PC_W-2){1'b1}}, 2'b00};
    localparam logic [3:0]      FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            flush_cnt <= '0;
            sepc_q    <= '0;
            scause_q  <= '0;
            stvec_q   <= STVEC_RESET & WORD_MASK;
        end else begin
            state <= state_nxt;
            if (state == IDLE && exception_in) begin
                sepc_q    <= sepc_in;
                scause_q  <= scause_in;
                flush_cnt <= FLUSH_INIT;
            end else if (state == FLUSH && flush_cnt != 4'd0) begin
                flush_cnt <= flush_cnt - 4'd1;
            end
            // A write landing on the edge into REDIRECT is what REDIRECT presents.
            if (stvec_wr_en && state != HALT) begin
                stvec_q <= stvec_wr_data & WORD_MASK;
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        flush_if_id       = 1'b0;
        flush_id_ex       = 1'b0;
        flush_ex_mem      = 1'b0;
        stall_pc          = 1'b0;
        pc_redirect_valid = 1'b0;
        pc_redirect_addr  = '0;
        in_trap           = 1'b0;
        halted            = 1'b0;
        case (state)
            IDLE: begin
                if (exception_in) state_nxt = FLUSH;
            end
            FLUSH: begin
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
                stall_pc     = 1'b1;
                if (flush_cnt == 4'd0) state_nxt = REDIRECT;
            end
            REDIRECT: begin
                pc_redirect_valid = 1'b1;
                pc_redirect_addr  = stvec_q;
                flush_if_id       = 1'b1;
                state_nxt         = HANDLER;
            end
            HANDLER: begin
                in_trap = 1'b1;
                // A fault inside the handler wins over a simultaneous sret.
                if (exception_in)  state_nxt = HALT;
                else if (sret_in)  state_nxt = RETURN;
            end
            RETURN: begin
                pc_redirect_valid = 1'b1;
                pc_redirect_addr  = sepc_q;
                flush_if_id       = 1'b1;
                flush_id_ex       = 1'b1;
                in_trap           = 1'b1;
                state_nxt         = IDLE;
            end
            HALT: begin
                halted       = 1'b1;
                stall_pc     = 1'b1;
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: hand-derived vector table for the directed scenarios, then random stimulus against a cycle-count model.
module tb_trap_sequencer;

    localparam int F = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exception_in;
    logic [14:0] sepc_in;
    logic [63:0] scause_in;
    logic        sret_in;
    logic        stvec_wr_en;
    logic [14:0] stvec_wr_data;
    logic        flush_if_id, flush_id_ex, flush_ex_mem, stall_pc;
    logic        pc_redirect_valid;
    logic [14:0] pc_redirect_addr;
    logic [14:0] sepc_q;
    logic [63:0] scause_q;
    logic [14:0] stvec_q;
    logic        in_trap, halted;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    trap_sequencer #(
        .PC_W(15), .CAUSE_W(64), .FLUSH_CYCLES(F), .STVEC_RESET(15'h0100)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .exception_in(exception_in), .sepc_in(sepc_in), .scause_in(scause_in),
        .sret_in(sret_in), .stvec_wr_en(stvec_wr_en), .stvec_wr_data(stvec_wr_data),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
        .stall_pc(stall_pc), .pc_redirect_valid(pc_redirect_valid),
        .pc_redirect_addr(pc_redirect_addr), .sepc_q(sepc_q), .scause_q(scause_q),
        .stvec_q(stvec_q), .in_trap(in_trap), .halted(halted)
    );

    // Model: age counts cycles since the trapping exception was sampled (0 = not trapping).
    int          age;
    bit          returning;
    bit          dead;
    logic [14:0] m_sepc;
    logic [63:0] m_scause;
    logic [14:0] m_stvec;

    task automatic model_update();
        if (!rst_n) begin
            age = 0; returning = 0; dead = 0;
            m_sepc = '0; m_scause = '0; m_stvec = 15'h0100;
        end else if (!dead) begin
            if (stvec_wr_en) m_stvec = {stvec_wr_data[14:2], 2'b00};
            if (returning) begin
                returning = 0;
            end else if (age == 0) begin
                if (exception_in) begin
                    m_sepc = sepc_in; m_scause = scause_in; age = 1;
                end
            end else if (age <= F + 1) begin
                age = age + 1;
            end else if (exception_in) begin
                dead = 1; age = 0;
            end else if (sret_in) begin
                returning = 1; age = 0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    task automatic check_model();
        bit fl, redir;
        logic [14:0] addr;
        fl    = dead || (age >= 1 && age <= F);
        redir = !dead && (age == F + 1 || returning);
        addr  = (!dead && age == F + 1) ? m_stvec : (returning ? m_sepc : 15'h0);
        chk("m_flush_if_id",  flush_if_id,  fl || redir);
        chk("m_flush_id_ex",  flush_id_ex,  fl || returning);
        chk("m_flush_ex_mem", flush_ex_mem, fl);
        chk("m_stall_pc",     stall_pc,     fl);
        chk("m_redir_vld",    pc_redirect_valid, redir);
        chk("m_redir_addr",   pc_redirect_addr, addr);
        chk("m_in_trap",      in_trap, !dead && (age >= F + 2 || returning));
        chk("m_halted",       halted, dead);
        chk("m_sepc",         sepc_q, m_sepc);
        chk("m_scause",       scause_q, m_scause);
        chk("m_stvec",        stvec_q, m_stvec);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_model();
    endtask

    typedef struct {
        logic        rst_n, exc, sret, wen;
        logic [14:0] sepc, wdata;
        logic [63:0] cause;
        logic        e_flush, e_redir, e_in_trap, e_halted;
        logic [14:0] e_addr, e_sepc, e_stvec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic x, logic s, logic w, logic [14:0] pc, logic [14:0] wd,
                                logic [63:0] c, logic ef, logic er, logic et, logic eh,
                                logic [14:0] ea, logic [14:0] es, logic [14:0] ev);
        vec_t v;
        v.rst_n = r; v.exc = x; v.sret = s; v.wen = w; v.sepc = pc; v.wdata = wd; v.cause = c;
        v.e_flush = ef; v.e_redir = er; v.e_in_trap = et; v.e_halted = eh;
        v.e_addr = ea; v.e_sepc = es; v.e_stvec = ev;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0; exception_in = 1'b0; sret_in = 1'b0; stvec_wr_en = 1'b0;
        sepc_in = '0; scause_in = '0; stvec_wr_data = '0;
        age = 0; returning = 0; dead = 0; m_sepc = '0; m_scause = '0; m_stvec = 15'h0100;

        //           rst x s w  sepc     wdata    cause  fl rd it hl addr     sepc     stvec
        tbl.push_back(mk(0,0,0,0, 15'h0,    15'h0,    64'h0, 0,0,0,0, 15'h0,    15'h0,    15'h0100));
        tbl.push_back(mk(1,1,0,0, 15'h1000, 15'h0,    64'h2, 1,0,0,0, 15'h0,    15'h1000, 15'h0100));
        tbl.push_back(mk(1,1,0,0, 15'h1234, 15'h0,    64'h9, 1,0,0,0, 15'h0,    15'h1000, 15'h0100));
        tbl.push_back(mk(1,0,1,0, 15'h0,    15'h0,    64'h0, 1,0,0,0, 15'h0,    15'h1000, 15'h0100));
        tbl.push_back(mk(1,0,0,0, 15'h0,    15'h0,    64'h0, 0,1,0,0, 15'h0100, 15'h1000, 15'h0100));
        tbl.push_back(mk(1,0,0,0, 15'h0,    15'h0,    64'h0, 0,0,1,0, 15'h0,    15'h1000, 15'h0100));
        tbl.push_back(mk(1,0,1,0, 15'h0,    15'h0,    64'h0, 0,1,1,0, 15'h1000, 15'h1000, 15'h0100));
        tbl.push_back(mk(1,1,0,0, 15'h1111, 15'h0,    64'h7, 0,0,0,0, 15'h0,    15'h1000, 15'h0100));
        tbl.push_back(mk(1,0,1,0, 15'h0,    15'h0,    64'h0, 0,0,0,0, 15'h0,    15'h1000, 15'h0100));
        tbl.push_back(mk(1,0,0,1, 15'h0,    15'h2003, 64'h0, 0,0,0,0, 15'h0,    15'h1000, 15'h2000));
        tbl.push_back(mk(1,1,0,0, 15'h1008, 15'h0,    64'h5, 1,0,0,0, 15'h0,    15'h1008, 15'h2000));
        tbl.push_back(mk(1,0,0,0, 15'h0,    15'h0,    64'h0, 1,0,0,0, 15'h0,    15'h1008, 15'h2000));
        tbl.push_back(mk(1,0,0,0, 15'h0,    15'h0,    64'h0, 1,0,0,0, 15'h0,    15'h1008, 15'h2000));
        tbl.push_back(mk(1,0,0,0, 15'h0,    15'h0,    64'h0, 0,1,0,0, 15'h2000, 15'h1008, 15'h2000));
        tbl.push_back(mk(1,0,0,0, 15'h0,    15'h0,    64'h0, 0,0,1,0, 15'h0,    15'h1008, 15'h2000));
        tbl.push_back(mk(1,1,1,0, 15'h1004, 15'h0,    64'h3, 1,0,0,1, 15'h0,    15'h1008, 15'h2000));
        tbl.push_back(mk(1,0,1,1, 15'h0,    15'h4000, 64'h0, 1,0,0,1, 15'h0,    15'h1008, 15'h2000));
        tbl.push_back(mk(1,1,0,0, 15'h0,    15'h0,    64'h0, 1,0,0,1, 15'h0,    15'h1008, 15'h2000));
        tbl.push_back(mk(0,0,0,0, 15'h0,    15'h0,    64'h0, 0,0,0,0, 15'h0,    15'h0,    15'h0100));
        tbl.push_back(mk(1,1,0,0, 15'h1010, 15'h0,    64'h1, 1,0,0,0, 15'h0,    15'h1010, 15'h0100));
        tbl.push_back(mk(0,0,0,0, 15'h0,    15'h0,    64'h0, 0,0,0,0, 15'h0,    15'h0,    15'h0100));
        tbl.push_back(mk(1,0,0,0, 15'h0,    15'h0,    64'h0, 0,0,0,0, 15'h0,    15'h0,    15'h0100));

        @(negedge clk);
        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n; exception_in = tbl[i].exc; sret_in = tbl[i].sret;
            stvec_wr_en = tbl[i].wen; sepc_in = tbl[i].sepc; scause_in = tbl[i].cause;
            stvec_wr_data = tbl[i].wdata;
            step();
            chk($sformatf("t%0d_flush_ex_mem", i), flush_ex_mem, tbl[i].e_flush);
            chk($sformatf("t%0d_stall_pc", i), stall_pc, tbl[i].e_flush);
            chk($sformatf("t%0d_redir_vld", i), pc_redirect_valid, tbl[i].e_redir);
            chk($sformatf("t%0d_redir_addr", i), pc_redirect_addr, tbl[i].e_addr);
            chk($sformatf("t%0d_in_trap", i), in_trap, tbl[i].e_in_trap);
            chk($sformatf("t%0d_halted", i), halted, tbl[i].e_halted);
            chk($sformatf("t%0d_sepc", i), sepc_q, tbl[i].e_sepc);
            chk($sformatf("t%0d_stvec", i), stvec_q, tbl[i].e_stvec);
        end
        chk("t_scause_after_reset", scause_q, 64'h0);

        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            rst_n         = ($urandom_range(0, 99) != 0);
            exception_in  = ($urandom_range(0, 7) == 0);
            sret_in       = ($urandom_range(0, 3) == 0);
            stvec_wr_en   = ($urandom_range(0, 9) == 0);
            sepc_in       = 15'($urandom);
            scause_in     = {$urandom, $urandom};
            stvec_wr_data = 15'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
